// File: rtl/gh_pkg.sv
// Shared definitions for the guitar-hero lane engine: lane-index width,
// judge result encoding, default playfield geometry and a BCD helper.
package gh_pkg;

    // Width of a lane index; never zero so a 1-lane build still has a port.
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Outcome of a button press in one lane.
    typedef enum logic [1:0] {
        JUDGE_NONE = 2'd0,
        JUDGE_HIT  = 2'd1,
        JUDGE_MISS = 2'd2
    } judge_e;

    localparam int GH_Y_MAX   = 480;
    localparam int GH_HIT_Y   = 400;
    localparam int GH_HIT_WIN = 16;

    // Packed 4-digit BCD increment that sticks at 9999.
    function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v == 16'h9999) return v;
        for (int d = 0; d < 4; d++) begin
            if (c) begin
                if (r[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gh_lane.sv
// One lane of notes: slot allocation on spawn, per-frame advance with
// drop-out, and hit-window search on a press.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_tick frame pulse;
//   i_press press edge for this lane; i_spawn accepted spawn for this lane;
//   o_ready a slot is free; o_valid/o_y slot state (registered);
//   o_hit/o_miss combinational judge of this cycle (registered by the top).
module gh_lane
    import gh_pkg::*;
#(
    parameter int SLOTS   = 4,
    parameter int Y_W     = 10,
    parameter int Y_MAX   = GH_Y_MAX,
    parameter int HIT_Y   = GH_HIT_Y,
    parameter int HIT_WIN = GH_HIT_WIN,
    parameter int SPEED   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_press,
    input  logic               i_spawn,
    output logic               o_ready,
    output logic [SLOTS-1:0]   o_valid,
    output logic [SLOTS*Y_W-1:0] o_y,
    output logic               o_hit,
    output logic               o_miss
);

    localparam int WIN_LO = HIT_Y - HIT_WIN;
    localparam int WIN_HI = HIT_Y + HIT_WIN;

    logic [Y_W-1:0]   r_y [SLOTS];
    logic [SLOTS-1:0] r_valid;

    logic [SLOTS-1:0] w_free_oh;
    logic [SLOTS-1:0] w_hit_oh;
    logic [SLOTS-1:0] w_in_win;
    logic [SLOTS-1:0] w_drop;
    judge_e           w_judge;

    always_comb begin
        w_free_oh = '0;
        w_hit_oh  = '0;
        w_in_win  = '0;
        w_drop    = '0;
        for (int s = 0; s < SLOTS; s++) begin
            w_in_win[s] = r_valid[s]
                       && (int'(r_y[s]) >= WIN_LO)
                       && (int'(r_y[s]) <= WIN_HI);
        end
        // Scan high to low so the lowest index ends up selected.
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (!r_valid[s]) begin
                w_free_oh    = '0;
                w_free_oh[s] = 1'b1;
            end
            if (w_in_win[s]) begin
                w_hit_oh    = '0;
                w_hit_oh[s] = 1'b1;
            end
        end
        if (!i_press) w_hit_oh = '0;
        // A hit slot is removed, so it can never also drop out.
        for (int s = 0; s < SLOTS; s++) begin
            w_drop[s] = i_tick && r_valid[s] && !w_hit_oh[s]
                     && (int'(r_y[s]) + SPEED >= Y_MAX);
        end
        if (!i_press)        w_judge = JUDGE_NONE;
        else if (|w_hit_oh)  w_judge = JUDGE_HIT;
        else                 w_judge = JUDGE_MISS;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            for (int s = 0; s < SLOTS; s++) r_y[s] <= '0;
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (w_hit_oh[s] || w_drop[s]) begin
                    r_valid[s] <= 1'b0;
                    r_y[s]     <= '0;
                end else if (i_spawn && w_free_oh[s]) begin
                    r_valid[s] <= 1'b1;
                    r_y[s]     <= '0;
                end else if (i_tick && r_valid[s]) begin
                    r_y[s] <= r_y[s] + Y_W'(SPEED);
                end
            end
        end
    end

    always_comb begin
        o_y = '0;
        for (int s = 0; s < SLOTS; s++) o_y[s*Y_W +: Y_W] = r_y[s];
    end

    assign o_valid = r_valid;
    assign o_ready = ~&r_valid;
    assign o_hit   = (w_judge == JUDGE_HIT);
    assign o_miss  = (w_judge == JUDGE_MISS) || (|w_drop);

endmodule

// File: rtl/gh_lane_engine.sv
// Guitar-hero game core: button synchronisers, N_LANES note lanes, and
// saturating score/combo. Optional macro GH_BCD_SCORE_EN makes Score BCD.
// Ports: ClkPort/RstN clock and async active-low reset; FrameTick frame pulse;
//   Btn raw button levels; SpawnValid/SpawnLane/SpawnReady spawn handshake;
//   NoteValid/NoteY flattened slot state; HitPulse/MissPulse per-lane pulses;
//   Score/Combo game counters. All outputs registered except SpawnReady.
module gh_lane_engine
    import gh_pkg::*;
#(
    parameter int N_LANES     = 4,
    parameter int SLOTS       = 4,
    parameter int Y_W         = 10,
    parameter int Y_MAX       = GH_Y_MAX,
    parameter int HIT_Y       = GH_HIT_Y,
    parameter int HIT_WIN     = GH_HIT_WIN,
    parameter int SPEED       = 2,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8,
    parameter int BONUS_COMBO = 10
) (
    input  logic                         ClkPort,
    input  logic                         RstN,
    input  logic                         FrameTick,
    input  logic [N_LANES-1:0]           Btn,
    input  logic                         SpawnValid,
    input  logic [lane_w(N_LANES)-1:0]   SpawnLane,
    output logic                         SpawnReady,
    output logic [N_LANES*SLOTS-1:0]     NoteValid,
    output logic [N_LANES*SLOTS*Y_W-1:0] NoteY,
    output logic [N_LANES-1:0]           HitPulse,
    output logic [N_LANES-1:0]           MissPulse,
    output logic [SCORE_W-1:0]           Score,
    output logic [COMBO_W-1:0]           Combo
);

    localparam int ADD_W = $clog2(2 * N_LANES + 1);

`ifdef GH_BCD_SCORE_EN
    if (SCORE_W != 16) begin : g_bad_score_w
        $error("GH_BCD_SCORE_EN needs SCORE_W == 16");
    end
`endif

    logic [N_LANES-1:0] r_btn_s1;
    logic [N_LANES-1:0] r_btn_s2;
    logic [N_LANES-1:0] r_btn_d;
    logic [N_LANES-1:0] r_hit;
    logic [N_LANES-1:0] r_miss;
    logic [SCORE_W-1:0] r_score;
    logic [COMBO_W-1:0] r_combo;

    logic [N_LANES-1:0] w_press;
    logic [N_LANES-1:0] w_spawn;
    logic [N_LANES-1:0] w_ready;
    logic [N_LANES-1:0] w_hit;
    logic [N_LANES-1:0] w_miss;
    logic [ADD_W-1:0]   w_nhits;
    logic [ADD_W-1:0]   w_add;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [COMBO_W-1:0] w_combo_nxt;

    assign w_press = r_btn_s2 & ~r_btn_d;

    assign SpawnReady = (int'(SpawnLane) < N_LANES) && w_ready[SpawnLane];

    always_comb begin
        w_spawn = '0;
        for (int l = 0; l < N_LANES; l++) begin
            w_spawn[l] = SpawnValid && SpawnReady && (int'(SpawnLane) == l);
        end
    end

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        gh_lane #(
            .SLOTS   (SLOTS),
            .Y_W     (Y_W),
            .Y_MAX   (Y_MAX),
            .HIT_Y   (HIT_Y),
            .HIT_WIN (HIT_WIN),
            .SPEED   (SPEED)
        ) u_lane (
            .i_clk   (ClkPort),
            .i_rst_n (RstN),
            .i_tick  (FrameTick),
            .i_press (w_press[l]),
            .i_spawn (w_spawn[l]),
            .o_ready (w_ready[l]),
            .o_valid (NoteValid[l*SLOTS +: SLOTS]),
            .o_y     (NoteY[l*SLOTS*Y_W +: SLOTS*Y_W]),
            .o_hit   (w_hit[l]),
            .o_miss  (w_miss[l])
        );
    end

    // Every hit this cycle is worth the same, judged on the pre-cycle combo.
    always_comb begin
        logic [SCORE_W:0] v_sum;
        logic [COMBO_W:0] v_csum;
        logic [15:0]      v_bcd;
        w_nhits = '0;
        for (int l = 0; l < N_LANES; l++) w_nhits = w_nhits + ADD_W'(w_hit[l]);
        w_add = (int'(r_combo) >= BONUS_COMBO) ? (w_nhits << 1) : w_nhits;

        v_sum = {1'b0, r_score} + (SCORE_W+1)'(w_add);
        v_bcd = 16'(r_score);
`ifdef GH_BCD_SCORE_EN
        for (int i = 0; i < 2 * N_LANES; i++) begin
            if (i < int'(w_add)) v_bcd = bcd_inc_sat(v_bcd);
        end
        w_score_nxt = SCORE_W'(v_bcd);
`else
        w_score_nxt = v_sum[SCORE_W] ? '1 : v_sum[SCORE_W-1:0];
`endif

        v_csum = {1'b0, r_combo} + (COMBO_W+1)'(w_nhits);
        if (|w_miss)             w_combo_nxt = '0;
        else if (v_csum[COMBO_W]) w_combo_nxt = '1;
        else                     w_combo_nxt = v_csum[COMBO_W-1:0];
    end

    always_ff @(posedge ClkPort or negedge RstN) begin
        if (!RstN) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_btn_d  <= '0;
            r_hit    <= '0;
            r_miss   <= '0;
            r_score  <= '0;
            r_combo  <= '0;
        end else begin
            r_btn_s1 <= Btn;
            r_btn_s2 <= r_btn_s1;
            r_btn_d  <= r_btn_s2;
            r_hit    <= w_hit;
            r_miss   <= w_miss;
            r_score  <= w_score_nxt;
            r_combo  <= w_combo_nxt;
        end
    end

    assign HitPulse  = r_hit;
    assign MissPulse = r_miss;
    assign Score     = r_score;
    assign Combo     = r_combo;

endmodule

// File: tb/tb_gh_lane_engine.sv
// Scoreboard bench for gh_lane_engine: expected hit/miss events are queued
// when presses and ticks are driven and compared when pulses appear.
module tb_gh_lane_engine;
    import gh_pkg::*;

`ifdef GH_BCD_SCORE_EN
    localparam int SMAX = 9999;
    localparam int SPRE = 9998;
`else
    localparam int SMAX = 65535;
    localparam int SPRE = 65534;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  btn = '0;
    logic        spv = 1'b0;
    logic [1:0]  spl = '0;
    logic        SpawnReady;
    logic [15:0] NoteValid;
    logic [159:0] NoteY;
    logic [3:0]  HitPulse;
    logic [3:0]  MissPulse;
    logic [15:0] Score;
    logic [7:0]  Combo;

    gh_lane_engine dut (
        .ClkPort    (clk),
        .RstN       (rst_n),
        .FrameTick  (tick),
        .Btn        (btn),
        .SpawnValid (spv),
        .SpawnLane  (spl),
        .SpawnReady (SpawnReady),
        .NoteValid  (NoteValid),
        .NoteY      (NoteY),
        .HitPulse   (HitPulse),
        .MissPulse  (MissPulse),
        .Score      (Score),
        .Combo      (Combo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  hit;
        logic [3:0]  miss;
        logic [15:0] score;
        logic [7:0]  combo;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  m_score = 0;
    int  m_combo = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int v);
`ifdef GH_BCD_SCORE_EN
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
`else
        return 16'(v);
`endif
    endfunction

    task automatic expect_evt(input logic [3:0] hits, input logic [3:0] miss);
        ev_t e;
        int  n;
        n = $countones(hits);
        m_score = m_score + n * ((m_combo >= 10) ? 2 : 1);
        if (m_score > SMAX) m_score = SMAX;
        if (miss != 0) m_combo = 0;
        else m_combo = (m_combo + n > 255) ? 255 : m_combo + n;
        e.hit   = hits;
        e.miss  = miss;
        e.score = enc(m_score);
        e.combo = 8'(m_combo);
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (HitPulse != 0 || MissPulse != 0)) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {HitPulse, MissPulse}, 0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("hit_pulse", HitPulse, e.hit);
                chk("miss_pulse", MissPulse, e.miss);
                chk("score", Score, e.score);
                chk("combo", Combo, e.combo);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic spawn(input int lane);
        spv = 1'b1;
        spl = 2'(lane);
        step();
        spv = 1'b0;
    endtask

    task automatic press(input logic [3:0] mask, input logic [3:0] hits,
                         input logic [3:0] miss);
        expect_evt(hits, miss);
        btn = mask;
        repeat (3) step();
        btn = '0;
        repeat (3) step();
    endtask

    task automatic round4();
        for (int l = 0; l < 4; l++) spawn(l);
        frames(200);
        press(4'hF, 4'hF, 4'h0);
    endtask

    initial begin
        // Reset with activity on the inputs.
        btn = 4'hF;
        tick = 1'b1;
        spv = 1'b1;
        repeat (3) step();
        chk("rst_valid", NoteValid, 0);
        chk("rst_y", NoteY, 0);
        chk("rst_score", Score, 0);
        chk("rst_combo", Combo, 0);
        chk("rst_pulses", {HitPulse, MissPulse}, 0);
        btn = '0;
        tick = 1'b0;
        spv = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("post_rst_score", Score, 0);
        chk("post_rst_valid", NoteValid, 0);
        chk("post_rst_ready", SpawnReady, 1);

        // Single hit with latency check.
        spawn(1);
        chk("spawn_slot", NoteValid, 16'h0010);
        frames(200);
        chk("y_400", NoteY[40 +: 10], 400);
        expect_evt(4'b0010, 4'b0000);
        btn = 4'b0010;
        step();
        step();
        chk("hit_early", HitPulse, 0);
        step();
        chk("hit_lat3", HitPulse, 4'b0010);
        btn = '0;
        repeat (3) step();
        chk("hit_cleared", NoteValid, 0);

        // Drop-out at Y_MAX.
        spawn(0);
        frames(239);
        chk("pre_drop_valid", NoteValid, 16'h0001);
        chk("pre_drop_y", NoteY[0 +: 10], 478);
        expect_evt(4'b0000, 4'b0001);
        frames(1);
        step();
        chk("drop_cleared", NoteValid, 0);

        // Build combo to 5, then a stray press.
        round4();
        spawn(2);
        frames(200);
        press(4'b0100, 4'b0100, 4'b0000);
        chk("combo5", Combo, 5);
        press(4'b0100, 4'b0000, 4'b0100);
        chk("stray_combo", Combo, 0);
        chk("stray_score", Score, enc(6));

        // Combo past the bonus threshold.
        round4();
        round4();
        round4();
        round4();
        chk("bonus_score", Score, enc(26));

        // Fill lane 3, refuse a fifth spawn.
        spl = 2'd3;
        for (int i = 0; i < 4; i++) begin
            #0;
            chk("ready_fill", SpawnReady, 1);
            spawn(3);
        end
        chk("ready_full", SpawnReady, 0);
        spawn(3);
        chk("full_valid", NoteValid, 16'hF000);
        spl = 2'd0;
        #1;
        chk("ready_other", SpawnReady, 1);
        frames(200);
        press(4'b1000, 4'b1000, 4'b0000);
        chk("after_hit_valid", NoteValid, 16'hE000);
        spl = 2'd3;
        #1;
        chk("ready_freed", SpawnReady, 1);

        // Saturation from a preloaded score.
        force dut.r_score = enc(SPRE);
        repeat (2) step();
        release dut.r_score;
        step();
        m_score = SPRE;
        chk("preload", Score, enc(SPRE));
        press(4'b1000, 4'b1000, 4'b0000);
        chk("sat_score", Score, enc(SMAX));
        press(4'b1000, 4'b1000, 4'b0000);
        chk("sat_hold", Score, enc(SMAX));
        chk("last_valid", NoteValid, 16'h8000);
        frames(39);
        expect_evt(4'b0000, 4'b1000);
        frames(1);
        repeat (4) step();
        chk("final_valid", NoteValid, 0);
        chk("final_combo", Combo, 0);
        chk("sb_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
